alu_muldiv_seq: RTL
===================

// Module: alu_muldiv_seq
// PURPOSE
// Registered, parametrised ALU for the next-gen MIPS datapath. Keeps legacy op codes 0-3
// (ADD/AND/OR/EQ) bit-exact and adds SUB/XOR/NOR/SLT/SLTU, iterative MULT/DIV (signed and
// unsigned) and HI/LO registers. Driven by the control FSM via a start/busy/done handshake.
// PARAMETERS
// WIDTH  32  operand/result width (>=4, even)
// OPW    4   op-code width
// PORTS
// clk     in   1        rising-edge clock
// rst_n   in   1        async active-low reset
// start   in   1        issue op; sampled only when busy==0
// op      in   OPW      op code (see BEHAVIOUR)
// a       in   WIDTH    operand 1 (dividend / multiplicand)
// b       in   WIDTH    operand 2 (divisor / multiplier)
// result  out  WIDTH    registered result, held until next done
// zero    out  1        result == 0, registered with result
// busy    out  1        op in flight; new start ignored
// done    out  1        one-cycle pulse, result/hi/lo valid this cycle
// hi      out  WIDTH    HI register
// lo      out  WIDTH    LO register
// BEHAVIOUR
// - Reset (async, rst_n=0): result=0, zero=1, busy=0, done=0, hi=0, lo=0, FSM->IDLE.
// - Op codes: 0 ADD, 1 AND, 2 OR, 3 EQ (result=1 if a==b else 0), 4 SUB, 5 XOR, 6 NOR,
//   7 SLT (signed), 8 SLTU, 9 MULT, 10 MULTU, 11 DIV, 12 DIVU, 13 MFHI, 14 MFLO, 15 -> result 0.
// - Arithmetic mod 2^WIDTH, no overflow trap. zero always = (result==0) of the same op.
// - FSM: IDLE -> (start, basic op) DONE; IDLE -> (start, mul/div) RUN; RUN counts WIDTH
//   iterations -> FIX; FIX -> DONE; DONE -> IDLE. done=1 only in DONE; busy=1 in RUN/FIX/DONE.
// - Latency, start sampled at edge E0: basic ops (0-8,13-15) done high after E0+1;
//   mul/div done high after E0+WIDTH+2. Next start accepted earliest at edge after done.
// - a, b, op captured at E0; later changes on inputs have no effect.
// - MULT/MULTU: shift-add on magnitudes; FIX applies sign; {hi,lo}=2*WIDTH product; result=lo.
// - DIV/DIVU: restoring division on magnitudes; lo=quotient (truncate toward zero),
//   hi=remainder (sign of dividend); result=lo. Signed MIN/-1: lo=MIN, hi=0.
// - Divide by zero (b==0): no iteration; done after E0+1; lo=all ones, hi=a; result=lo.
// - MFHI/MFLO: result=hi/lo; hi/lo unchanged. Basic ops never modify hi/lo.
// - hi/lo update only in the DONE cycle of a mul/div; hold otherwise.
// - start while busy: ignored, no queuing. start with done in same cycle: ignored.
// - Reset mid-operation: immediate abort, all outputs to reset values, no done pulse.
// STRUCTURE
// - alu_pkg: op-code localparams (OP_ADD..OP_MFLO), FSM state enum {IDLE,RUN,FIX,DONE}.
// - Sub-module muldiv_iter: iterative engine (acc/quot regs, count, sign flags);
//   load/step/fix controls from the top FSM; top holds basic-op datapath, hi/lo, outputs.
// TESTING
// - ADD a=5,b=7 -> done 1 cycle after start, result=12, zero=0; EQ 9,9 -> result=1.
// - SUB 3,3 -> result=0, zero=1; SLT -1,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0.
// - MULT -3,7 -> done at E0+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB, result=lo; MULTU 0xFFFFFFFF^2 ->
//   hi=0xFFFFFFFE, lo=1.
// - DIV -7,2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7,0 -> done at E0+1, lo=0xFFFFFFFF, hi=7.
// - start pulsed during MULT busy with ADD -> ignored; MULT result unchanged; then MFHI -> hi.
// - rst_n low at E0+10 of DIVU -> busy=0, result=0, hi=lo=0, no done; new op runs normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op-code map and control FSM states for the registered MIPS ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_EQ   = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_MULT = 4'd9;
  localparam logic [3:0] OP_MULTU = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_MFHI = 4'd13;
  localparam logic [3:0] OP_MFLO = 4'd14;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine on operand magnitudes, one bit per step;
// sign correction of the final {hi,lo} is applied while fix is asserted.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [CW-1:0]      count_q, count_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, shifted, trial;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    mag_a   = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b   = (is_signed && b[WIDTH-1]) ? -b : b;
    // multiply: {acc,quot} shifts right; divide: {acc,quot} shifts left
    sum     = {1'b0, acc_q} + (quot_q[0] ? {1'b0, mb_q} : '0);
    shifted = {acc_q, quot_q[WIDTH-1]};
    trial   = shifted - {1'b0, mb_q};
    prod    = neg_q ? -{acc_q, quot_q} : {acc_q, quot_q};
  end

  always_comb begin
    acc_d     = acc_q;
    quot_d    = quot_q;
    mb_d      = mb_q;
    count_d   = count_q;
    div_d     = div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    if (load) begin
      acc_d     = '0;
      count_d   = '0;
      div_d     = is_div;
      neg_d     = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem_d = is_signed && is_div && a[WIDTH-1];
      quot_d    = is_div ? mag_a : mag_b;
      mb_d      = is_div ? mag_b : mag_a;
    end else if (step) begin
      count_d = count_q + CW'(1);
      if (div_q) begin
        if (!trial[WIDTH]) begin
          acc_d  = trial[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d  = shifted[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d  = sum[WIDTH:1];
        quot_d = {sum[0], quot_q[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    hi = acc_q;
    lo = quot_q;
    if (fix) begin
      if (div_q) begin
        hi = neg_rem_q ? -acc_q : acc_q;
        lo = neg_q ? -quot_q : quot_q;
      end else begin
        hi = prod[2*WIDTH-1:WIDTH];
        lo = prod[WIDTH-1:0];
      end
    end
  end

  assign last = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      quot_q    <= '0;
      mb_q      <= '0;
      count_q   <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      quot_q    <= quot_d;
      mb_q      <= mb_d;
      count_q   <= count_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Registered ALU with iterative MULT/DIV, HI/LO registers and start/busy/done handshake.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;

  logic [3:0]       op_n;
  logic [WIDTH-1:0] basic_res;
  logic             is_div_op, is_signed_op;
  logic             eng_load, eng_step, eng_fix, eng_last;
  logic [WIDTH-1:0] eng_hi, eng_lo;

  assign op_n         = 4'(op);
  assign is_div_op    = (op_n == OP_DIV) || (op_n == OP_DIVU);
  assign is_signed_op = (op_n == OP_MULT) || (op_n == OP_DIV);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (eng_load),
    .step     (eng_step),
    .fix      (eng_fix),
    .is_div   (is_div_op),
    .is_signed(is_signed_op),
    .a        (a),
    .b        (b),
    .last     (eng_last),
    .hi       (eng_hi),
    .lo       (eng_lo)
  );

  always_comb begin
    basic_res = '0;
    case (op_n)
      OP_ADD:  basic_res = a + b;
      OP_AND:  basic_res = a & b;
      OP_OR:   basic_res = a | b;
      OP_EQ:   basic_res = {{(WIDTH-1){1'b0}}, a == b};
      OP_SUB:  basic_res = a - b;
      OP_XOR:  basic_res = a ^ b;
      OP_NOR:  basic_res = ~(a | b);
      OP_SLT:  basic_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: basic_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_MFHI: basic_res = hi_q;
      OP_MFLO: basic_res = lo_q;
      default: basic_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    eng_load = 1'b0;
    eng_step = 1'b0;
    eng_fix  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!is_muldiv(op_n)) begin
            result_d = basic_res;
            state_d  = DONE;
          end else if (is_div_op && (b == '0)) begin
            result_d = '1;
            hi_d     = a;
            lo_d     = '1;
            state_d  = DONE;
          end else begin
            eng_load = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        eng_step = 1'b1;
        if (eng_last) state_d = FIX;
      end
      FIX: begin
        eng_fix  = 1'b1;
        result_d = eng_lo;
        hi_d     = eng_hi;
        lo_d     = eng_lo;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign done   = (state_q == DONE);
  assign busy   = (state_q != IDLE);

endmodule
